// File: rtl/rp_dac_tdm_formatter.sv
// Time-multiplexed DAC formatter: N_CH-sample frames are saturated, code-converted and
// serialised onto one DAC bus with a channel index, startup hold and frame-aligned mute.
module rp_dac_tdm_formatter #(
    parameter int N_CH        = 2,
    parameter int IN_W        = 16,
    parameter int DAC_W       = 14,
    parameter int FORMAT      = 2,
    parameter int STARTUP_CYC = 16,
    localparam int SW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 dac_clk,
    input  logic                 dac_rst,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [N_CH*IN_W-1:0] dat_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DAC_W-1:0]     dac_dat_o,
    output logic [SW-1:0]        dac_sel_o,
    output logic                 dac_frame_o,
    output logic                 mute_o,
    output logic [N_CH-1:0]      sat_o,
    output logic                 underrun_o
);

    localparam int CW = $clog2(STARTUP_CYC + 1);
    localparam logic [SW-1:0] LAST = SW'(N_CH - 1);
    localparam logic signed [IN_W-1:0] SMAX = IN_W'((1 << (DAC_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SMIN = ~SMAX;
    localparam logic [DAC_W-1:0] MID = (FORMAT == 1) ? {1'b1, {(DAC_W-1){1'b0}}} :
                                       (FORMAT == 2) ? {1'b0, {(DAC_W-1){1'b1}}} : '0;

    typedef enum logic [1:0] {STARTUP, RUN, MUTE} state_t;

    function automatic logic [DAC_W-1:0] fmt(input logic [DAC_W-1:0] v);
        if (FORMAT == 1)
            return {~v[DAC_W-1], v[DAC_W-2:0]};
        else if (FORMAT == 2)
            return {v[DAC_W-1], ~v[DAC_W-2:0]};
        else
            return v;
    endfunction

    state_t                 state;
    logic [SW-1:0]          slot;
    logic [CW-1:0]          cnt;
    logic [N_CH*IN_W-1:0]   frame;
    logic                   muted;
    logic                   fb;

    logic signed [IN_W-1:0] smp;
    logic [DAC_W-1:0]       clamped;
    logic [N_CH-1:0]        slot_vec;
    logic [N_CH-1:0]        sat_set;

    logic [SW-1:0]          s1_slot;
    logic                   s1_muted;
    logic [DAC_W-1:0]       s1_dat;

    assign fb      = (slot == LAST);
    assign ready_o = fb && (state != STARTUP);

    // Frame register and mute flag change only at frame boundaries, so every
    // slot of one frame sees a consistent (data, muted) pair.
    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            state      <= STARTUP;
            slot       <= LAST;
            cnt        <= '0;
            frame      <= '0;
            muted      <= 1'b1;
            underrun_o <= 1'b0;
        end else begin
            slot       <= fb ? '0 : slot + SW'(1);
            underrun_o <= (underrun_o && !clr_i) || (fb && state == RUN && !valid_i);
            if (state == STARTUP && cnt != CW'(STARTUP_CYC))
                cnt <= cnt + CW'(1);
            if (fb) begin
                case (state)
                    STARTUP: begin
                        if (cnt == CW'(STARTUP_CYC))
                            state <= en_i ? RUN : MUTE;
                    end
                    default: begin
                        state <= en_i ? RUN : MUTE;
                        muted <= !en_i;
                        if (valid_i)
                            frame <= dat_i;
                    end
                endcase
            end
        end
    end

    always_comb begin
        smp      = '0;
        slot_vec = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (slot == SW'(k)) begin
                smp         = frame[k*IN_W +: IN_W];
                slot_vec[k] = 1'b1;
            end
        end
        sat_set = slot_vec;
        if (smp > SMAX)
            clamped = SMAX[DAC_W-1:0];
        else if (smp < SMIN)
            clamped = SMIN[DAC_W-1:0];
        else begin
            clamped = smp[DAC_W-1:0];
            sat_set = '0;
        end
    end

    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            s1_slot     <= LAST;
            s1_muted    <= 1'b1;
            s1_dat      <= '0;
            sat_o       <= '0;
            dac_dat_o   <= MID;
            dac_sel_o   <= '0;
            dac_frame_o <= 1'b0;
            mute_o      <= 1'b1;
        end else begin
            s1_slot     <= slot;
            s1_muted    <= muted;
            s1_dat      <= clamped;
            sat_o       <= (sat_o & {N_CH{!clr_i}}) | sat_set;
            dac_dat_o   <= s1_muted ? MID : fmt(s1_dat);
            dac_sel_o   <= s1_slot;
            dac_frame_o <= (s1_slot == '0);
            mute_o      <= s1_muted;
        end
    end

endmodule
